uart_ring_fifo: RTL and testbench

Parametrised successor to the UART receive ring buffer: a single-clock circular FIFO between the UART byte receiver and the CPU-side read port. Width, depth and full-buffer policy (drop newest or overwrite oldest) are configurable. Occupancy, full/empty/almost-full flags and a sticky overflow indicator are exported for status registers and interrupt logic.

---
 rtl/uart_ring_fifo.sv | 105 ++++++++++
 tb/tb_uart_ring_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_ring_fifo.sv
// uart_ring_fifo: single-clock circular FIFO between the UART receiver
// and the CPU read port, with drop-newest or overwrite-oldest policy.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   writeEnable         push dataWrite this cycle
//   dataWrite           word to push
//   readRequest         pop request
//   dataReadAck         one-cycle pulse, dataRead holds a popped word
//   dataRead            popped word, held between acks
//   count               entries stored, 0..DEPTH
//   empty/full          count == 0 / count == DEPTH
//   almostFull          count >= ALMOST_FULL
//   overflow            sticky: a write was dropped or overwrote the oldest
//   clearOverflow       clears overflow (a same-cycle set wins)
module uart_ring_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int OVERWRITE   = 0,
    parameter int ALMOST_FULL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] dataWrite,
    input  logic                  readRequest,
    output logic                  dataReadAck,
    output logic [DATA_WIDTH-1:0] dataRead,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almostFull,
    output logic                  overflow,
    input  logic                  clearOverflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_C    = (DEPTH_LOG2+1)'(ALMOST_FULL);
    localparam logic [DEPTH_LOG2:0] CONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PONE  = DEPTH_LOG2'(1);
    localparam bit OW = (OVERWRITE != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countNext;
    logic                  readOk;
    logic                  wrAccept;
    logic                  wrOver;
    logic                  wrDrop;

    // A full buffer still accepts a write when a read frees a slot
    // in the same cycle.
    assign readOk   = readRequest && !empty;
    assign wrAccept = writeEnable && (!full || readOk);
    assign wrOver   = writeEnable && full && !readOk && OW;
    assign wrDrop   = writeEnable && full && !readOk && !OW;

    // An overwrite pushes one and discards one: no net change.
    always_comb begin
        countNext = count;
        if (wrAccept && !readOk)
            countNext = count + CONE;
        else if (readOk && !wrAccept)
            countNext = count - CONE;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && (wrAccept || wrOver))
            mem[wrPtr] <= dataWrite;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almostFull  <= 1'b0;
            overflow    <= 1'b0;
            dataReadAck <= 1'b0;
            dataRead    <= '0;
        end else begin
            dataReadAck <= readOk;
            if (readOk)
                dataRead <= mem[rdPtr];
            if (wrAccept || wrOver)
                wrPtr <= wrPtr + PONE;
            if (readOk || wrOver)
                rdPtr <= rdPtr + PONE;
            count      <= countNext;
            empty      <= (countNext == '0);
            full       <= (countNext == DEPTH_C);
            almostFull <= (countNext >= AF_C);
            if (wrDrop || wrOver)
                overflow <= 1'b1;
            else if (clearOverflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ring_fifo.sv
// tb_uart_ring_fifo: drives a drop-policy and an overwrite-policy FIFO
// with the same stimulus and compares both against queue models.
module tb_uart_ring_fifo;

    typedef logic [7:0] q_t[$];

    typedef struct {
        logic       we;
        logic [7:0] d;
        logic       rr;
        int         cnt;
        logic       ack;
        logic [7:0] dr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, writeEnable, readRequest, clearOverflow;
    logic [7:0] dataWrite;

    logic       ack0, emp0, ful0, af0, ov0;
    logic [7:0] dr0;
    logic [4:0] cnt0;
    logic       ack1, emp1, ful1, af1, ov1;
    logic [7:0] dr1;
    logic [4:0] cnt1;

    int tests = 0;
    int fails = 0;

    q_t         mq0, mq1;
    logic       mov0, mov1, mack0, mack1;
    logic [7:0] mdr0, mdr1;

    always #5 clk = ~clk;

    uart_ring_fifo #(.OVERWRITE(0)) dut0 (
        .clk(clk), .reset(reset), .writeEnable(writeEnable),
        .dataWrite(dataWrite), .readRequest(readRequest),
        .dataReadAck(ack0), .dataRead(dr0), .count(cnt0),
        .empty(emp0), .full(ful0), .almostFull(af0),
        .overflow(ov0), .clearOverflow(clearOverflow)
    );

    uart_ring_fifo #(.OVERWRITE(1)) dut1 (
        .clk(clk), .reset(reset), .writeEnable(writeEnable),
        .dataWrite(dataWrite), .readRequest(readRequest),
        .dataReadAck(ack1), .dataRead(dr1), .count(cnt1),
        .empty(emp1), .full(ful1), .almostFull(af1),
        .overflow(ov1), .clearOverflow(clearOverflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a plain queue of stored words.
    task automatic mdl(input bit ow, input logic we, input logic [7:0] d,
                       input logic rr, input logic co, input logic rs,
                       inout q_t q, inout logic ov, inout logic ack,
                       inout logic [7:0] dr);
        int n;
        bit rok, set;
        if (rs) begin
            q.delete();
            ov = 1'b0; ack = 1'b0; dr = 8'h00;
            return;
        end
        n = q.size();
        rok = rr && (n > 0);
        set = 1'b0;
        ack = rok;
        if (rok) dr = q.pop_front();
        if (we) begin
            if (n < 16 || rok) q.push_back(d);
            else begin
                set = 1'b1;
                if (ow) begin
                    q.delete(0);
                    q.push_back(d);
                end
            end
        end
        if (set) ov = 1'b1;
        else if (co) ov = 1'b0;
    endtask

    task automatic check_all();
        chk("d0_cnt", 32'(cnt0), 32'(mq0.size()));
        chk("d0_empty", 32'(emp0), 32'(mq0.size() == 0));
        chk("d0_full", 32'(ful0), 32'(mq0.size() == 16));
        chk("d0_af", 32'(af0), 32'(mq0.size() >= 12));
        chk("d0_ovf", 32'(ov0), 32'(mov0));
        chk("d0_ack", 32'(ack0), 32'(mack0));
        chk("d0_data", 32'(dr0), 32'(mdr0));
        chk("d1_cnt", 32'(cnt1), 32'(mq1.size()));
        chk("d1_empty", 32'(emp1), 32'(mq1.size() == 0));
        chk("d1_full", 32'(ful1), 32'(mq1.size() == 16));
        chk("d1_af", 32'(af1), 32'(mq1.size() >= 12));
        chk("d1_ovf", 32'(ov1), 32'(mov1));
        chk("d1_ack", 32'(ack1), 32'(mack1));
        chk("d1_data", 32'(dr1), 32'(mdr1));
    endtask

    task automatic step(input logic we, input logic [7:0] d,
                        input logic rr, input logic co, input logic rs);
        writeEnable   = we;
        dataWrite     = d;
        readRequest   = rr;
        clearOverflow = co;
        reset         = rs;
        @(posedge clk);
        #1;
        mdl(1'b0, we, d, rr, co, rs, mq0, mov0, mack0, mdr0);
        mdl(1'b1, we, d, rr, co, rs, mq1, mov1, mack1, mdr1);
        check_all();
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{1'b1, 8'h12, 1'b0, 1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h23, 1'b0, 2, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h12};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h23};

        writeEnable = 0; dataWrite = 0; readRequest = 0;
        clearOverflow = 0; reset = 1;
        @(negedge clk);

        // reset state
        step(0, 8'h00, 0, 0, 1);
        chk("rst_empty", 32'(emp0), 1);
        chk("rst_cnt", 32'(cnt0), 0);

        // basic write/read table
        for (int i = 0; i < 4; i++) begin
            step(tbl[i].we, tbl[i].d, tbl[i].rr, 0, 0);
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ack", i), 32'(ack0), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_dr", i), 32'(dr0), 32'(tbl[i].dr));
        end
        chk("tbl_empty", 32'(emp0), 1);

        // read while empty, then read+write while empty
        step(0, 8'h00, 1, 0, 0);
        chk("rd_empty_ack", 32'(ack0), 0);
        chk("rd_empty_dr", 32'(dr0), 32'h23);
        step(1, 8'h55, 1, 0, 0);
        chk("rdwr_empty_cnt", 32'(cnt0), 1);
        chk("rdwr_empty_ack", 32'(ack0), 0);

        // 17 writes: drop vs overwrite
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
        chk("ovf0_full", 32'(ful0), 1);
        chk("ovf0_flag", 32'(ov0), 1);
        chk("ovf1_cnt", 32'(cnt1), 16);
        chk("ovf1_flag", 32'(ov1), 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            chk("ovf0_order", 32'(dr0), 32'(i));
            chk("ovf1_order", 32'(dr1), 32'(i + 1));
        end

        // full with simultaneous read and write
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        chk("fullrw_ack", 32'(ack0), 1);
        chk("fullrw_dr", 32'(dr0), 32'h40);
        chk("fullrw_cnt", 32'(cnt0), 16);
        chk("fullrw_ovf", 32'(ov0), 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        chk("fullrw_last", 32'(dr0), 32'hAA);

        // clear in the same cycle as a dropped write
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'h77, 0, 1, 0);
        chk("clr_set_prio", 32'(ov0), 1);
        step(0, 8'h00, 0, 1, 0);
        chk("clr_done", 32'(ov0), 0);

        // interleaved stream with wrap and mid-stream reset
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            if (i == 30) begin
                step(1, 8'(i), 1, 0, 1);
                chk("mid_rst_cnt", 32'(cnt0), 0);
                chk("mid_rst_ack", 32'(ack0), 0);
                chk("mid_rst_dr", 32'(dr0), 0);
            end else begin
                step(1, 8'(8'h80 + i), (i % 3) == 2, 0, 0);
            end
        end
        for (int i = 0; i < 40; i++) step(i < 20, 8'(i), i >= 6, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
